mod107_weight_unscaler: RTL and testbench

- Inverse-direction companion to the chunk-weight forward LUTs of the mod-107 converter.
- The forward LUTs turn a 6-bit chunk at position j into (chunk * 2^(6j)) mod 107. This block takes a 7-bit residue and removes a positional weight of 2^K.
- It outputs (r * 2^(-K)) mod 107 by iterative modular halving, one halving step per clock.
- It sits after the residue accumulator, so a residue can be re-normalised to chunk position 0 before comparison or reverse conversion.

---
 rtl/mod107_weight_unscaler.sv | 103 ++++++++++
 tb/tb_mod107_weight_unscaler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod107_weight_unscaler.sv
// Removes a positional weight 2^K from a residue: out = (r * 2^-K) mod MOD, by modular halving.
// Latency: K+1 clock edges from the input handshake edge (counting that edge) to out_valid.
// Backpressure: single request in flight; in_ready only in IDLE; result held until out_ready.
module mod107_weight_unscaler #(
    parameter int MOD = 107,
    parameter int KW  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    in_res,
    input  logic [KW-1:0] in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [6:0]    out_res,
    output logic          busy
);

    localparam logic [7:0] MOD8 = 8'(MOD);
    localparam logic [6:0] MOD7 = 7'(MOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    acc, acc_nxt;
    logic [KW-1:0] cnt, cnt_nxt;
    logic [6:0]    res_q, res_nxt;

    logic [6:0]    in_red;
    logic [7:0]    half_sum;
    logic [6:0]    acc_half;

    // One conditional subtraction reduces 0..127 into 0..MOD-1 since 127-MOD < MOD.
    assign in_red = (in_res >= MOD7) ? (in_res - MOD7) : in_res;

    // Odd acc: adding odd MOD makes it even, so the shift is an exact division by 2 mod MOD.
    assign half_sum = {1'b0, acc} + (acc[0] ? MOD8 : 8'd0);
    assign acc_half = half_sum[7:1];

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        res_nxt   = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt = in_red;
                    cnt_nxt = in_k;
                    if (in_k != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                        res_nxt   = in_red;
                    end
                end
            end
            RUN: begin
                acc_nxt = acc_half;
                cnt_nxt = cnt - 1'b1;
                if (cnt == KW'(1)) begin
                    state_nxt = DONE;
                    res_nxt   = acc_half;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            res_q <= res_nxt;
        end
    end

    assign out_res = res_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mod107_weight_unscaler.sv
// Scoreboard bench for mod107_weight_unscaler: directed vectors, reset, backpressure and a soak.
`timescale 1ns/1ps
module tb_mod107_weight_unscaler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] in_res = '0;
    logic [6:0] in_k = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_res;
    logic       busy;

    mod107_weight_unscaler #(.MOD(107), .KW(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      res;
        longint  hs;
        int      k;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    bit     rand_ready = 1'b0;
    bit     seen = 1'b0;
    longint rise_t = 0;

    function automatic int ref_model(int r, int k);
        int e = 106 - (k % 106);
        int v = 1;
        for (int i = 0; i < e; i++) v = (v * 2) % 107;
        return ((r % 107) * v) % 107;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a handshake happens on the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen   = 1'b1;
                rise_t = $time - 5;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_res=%0d, expected no output", out_res);
                end else begin
                    e = sb.pop_front();
                    chk("out_res", int'(out_res), e.res);
                    chk("latency_edges", int'((rise_t - e.hs) / 10) + 1, e.k + 1);
                end
                seen = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int r, input int k, input int expv);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_res   = 7'(r);
        in_k     = 7'(k);
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 500 cycles");
        end else begin
            sb.push_back('{res: expv, hs: longint'($time) + 5, k: k});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int r, k, n;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_res", int'(out_res), 0);
        chk("rst_busy", int'(busy), 0);
        #21 rst_n = 1'b1;
        out_ready = 1'b1;

        // Reset in the middle of a long run abandons it without output.
        send(50, 100, 0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(3, 2, 81);
        drain();

        // Directed values
        send(1, 1, 54);
        send(2, 1, 1);
        send(3, 2, 81);
        send(0, 90, 0);
        send(1, 96, 61);
        send(106, 96, 46);
        send(120, 0, 13);
        send(107, 0, 0);
        send(106, 0, 106);
        send(127, 106, 20);
        drain();

        // Result held under backpressure; stray requests ignored.
        out_ready = 1'b0;
        send(3, 2, 81);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_res", int'(out_res), 81);
            chk("bp_in_ready", int'(in_ready), 0);
            if (i == 3) begin
                in_valid = 1'b1;
                in_res   = 7'd5;
                in_k     = 7'd0;
            end
            if (i == 6) in_valid = 1'b0;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        drain();

        // Soak against the exponentiation model with random downstream stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 127);
            k = $urandom_range(0, 127);
            send(r, k, ref_model(r, k));
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
